// File: rtl/seg_display_driver.sv
// seg_display_driver: 4-digit 7-segment scan driver for the core debug bus.
// Define DISP_CHANGE_CNT_EN to show a frame change counter on DIG3.
module seg_display_driver #(
   parameter int unsigned REFRESH_DIV = 50000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] value,
   input  logic       mode,
   output logic [6:0] seg,
   output logic [3:0] an,
   output logic       dp
);

   localparam logic [15:0] DIV_LAST = 16'(REFRESH_DIV - 1);

   localparam logic [6:0] BLANK  = 7'b1111111;
   localparam logic [6:0] LTR_P  = 7'b0001100;
   localparam logic [6:0] LTR_A  = 7'b0001000;

   typedef enum logic [1:0] {
      DIG0,
      DIG1,
      DIG2,
      DIG3
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic [15:0] cnt;
   logic        tick;
   logic        frame;
   logic [7:0]  value_q;
   logic        mode_q;
   logic [7:0]  snap_value;
   logic        snap_mode;
   logic [6:0]  dig3_seg;
   logic [6:0]  seg_nxt;
   logic [3:0]  an_nxt;
   logic        dp_nxt;

   function automatic logic [6:0] hex7(input logic [3:0] n);
      logic [6:0] g;
      case (n)
         4'h0: g = 7'b1000000;
         4'h1: g = 7'b1111001;
         4'h2: g = 7'b0100100;
         4'h3: g = 7'b0110000;
         4'h4: g = 7'b0011001;
         4'h5: g = 7'b0010010;
         4'h6: g = 7'b0000010;
         4'h7: g = 7'b1111000;
         4'h8: g = 7'b0000000;
         4'h9: g = 7'b0010000;
         4'hA: g = 7'b0001000;
         4'hB: g = 7'b0000011;
         4'hC: g = 7'b1000110;
         4'hD: g = 7'b0100001;
         4'hE: g = 7'b0000110;
         default: g = 7'b0001110;
      endcase
      return g;
   endfunction

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         value_q <= '0;
         mode_q  <= 1'b0;
      end else begin
         value_q <= value;
         mode_q  <= mode;
      end
   end

   assign tick = (cnt == DIV_LAST);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else if (tick) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= DIG0;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      if (tick) begin
         unique case (state)
            DIG0: state_nxt = DIG1;
            DIG1: state_nxt = DIG2;
            DIG2: state_nxt = DIG3;
            DIG3: state_nxt = DIG0;
         endcase
      end
   end

   // One snapshot per frame keeps all four digits coherent
   assign frame = tick && (state == DIG3);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         snap_value <= '0;
         snap_mode  <= 1'b0;
      end else if (frame) begin
         snap_value <= value_q;
         snap_mode  <= mode_q;
      end
   end

`ifdef DISP_CHANGE_CNT_EN
   logic [3:0] chg_cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         chg_cnt <= '0;
      end else if (frame && (value_q != snap_value)) begin
         chg_cnt <= chg_cnt + 4'd1;
      end
   end

   assign dig3_seg = hex7(chg_cnt);
`else
   assign dig3_seg = BLANK;
`endif

   always_comb begin
      seg_nxt = BLANK;
      an_nxt  = 4'b1111;
      dp_nxt  = 1'b1;
      unique case (state)
         DIG0: begin
            seg_nxt = hex7(snap_value[3:0]);
            an_nxt  = 4'b1110;
         end
         DIG1: begin
            seg_nxt = hex7(snap_value[7:4]);
            an_nxt  = 4'b1101;
         end
         DIG2: begin
            seg_nxt = snap_mode ? LTR_P : LTR_A;
            an_nxt  = 4'b1011;
            dp_nxt  = 1'b0;
         end
         DIG3: begin
            seg_nxt = dig3_seg;
            an_nxt  = 4'b0111;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         seg <= BLANK;
         an  <= 4'b1111;
         dp  <= 1'b1;
      end else begin
         seg <= seg_nxt;
         an  <= an_nxt;
         dp  <= dp_nxt;
      end
   end

endmodule

// File: tb/tb_seg_display_driver.sv
// tb_seg_display_driver: frame-level model plus directed checks
// for seg_display_driver with REFRESH_DIV=4.
module tb_seg_display_driver;

   localparam int DIV   = 4;
   localparam int FRAME = 4 * DIV;

   logic       clk   = 1'b0;
   logic       rst   = 1'b1;
   logic [7:0] value = 8'h00;
   logic       mode  = 1'b0;
   logic [6:0] seg;
   logic [3:0] an;
   logic       dp;

   int checks = 0;
   int errors = 0;
   bit chk_on = 1'b0;

   logic [6:0] glyph [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
   };

   seg_display_driver #(.REFRESH_DIV(DIV)) dut (
      .clk  (clk),
      .rst  (rst),
      .value(value),
      .mode (mode),
      .seg  (seg),
      .an   (an),
      .dp   (dp)
   );

   always #5 clk = ~clk;

   // Model: edge count since release decides the digit; frame k
   // shows the input sampled one edge before the k-th frame edge.
   int         t      = 0;
   logic [7:0] prev_v = 8'h00;
   logic       prev_m = 1'b0;
   logic [7:0] m_v    = 8'h00;
   logic       m_m    = 1'b0;
`ifdef DISP_CHANGE_CNT_EN
   int         m_cnt  = 0;
`endif
   logic [6:0] e_seg  = 7'b1111111;
   logic [3:0] e_an   = 4'b1111;
   logic       e_dp   = 1'b1;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         t      = 0;
         prev_v = 8'h00;
         prev_m = 1'b0;
         m_v    = 8'h00;
         m_m    = 1'b0;
`ifdef DISP_CHANGE_CNT_EN
         m_cnt  = 0;
`endif
         e_seg  = 7'b1111111;
         e_an   = 4'b1111;
         e_dp   = 1'b1;
      end else begin
         int d;
         t = t + 1;
         d = ((t - 1) / DIV) % 4;
         e_an = 4'b1111;
         e_an[d] = 1'b0;
         e_dp = (d != 2);
         case (d)
            0: e_seg = glyph[m_v[3:0]];
            1: e_seg = glyph[m_v[7:4]];
            2: e_seg = m_m ? 7'b0001100 : 7'b0001000;
`ifdef DISP_CHANGE_CNT_EN
            default: e_seg = glyph[m_cnt % 16];
`else
            default: e_seg = 7'b1111111;
`endif
         endcase
         if (t % FRAME == 0) begin
`ifdef DISP_CHANGE_CNT_EN
            if (prev_v != m_v) m_cnt = (m_cnt + 1) % 16;
`endif
            m_v = prev_v;
            m_m = prev_m;
         end
         prev_v = value;
         prev_m = mode;
      end
   end

   always @(negedge clk) begin
      if (chk_on) begin
         checks++;
         if (seg !== e_seg || an !== e_an || dp !== e_dp) begin
            errors++;
            $display("FAIL cycle t=%0d got seg=%b an=%b dp=%b want seg=%b an=%b dp=%b",
                     t, seg, an, dp, e_seg, e_an, e_dp);
         end
      end
   end

   task automatic check_lit(input string name, input logic [6:0] s,
                            input logic [3:0] a, input logic d);
      checks++;
      if (seg !== s || an !== a || dp !== d) begin
         errors++;
         $display("FAIL %s got seg=%b an=%b dp=%b want seg=%b an=%b dp=%b",
                  name, seg, an, dp, s, a, d);
      end
      checks++;
      if (e_seg !== s || e_an !== a || e_dp !== d) begin
         errors++;
         $display("FAIL model_%s got seg=%b an=%b dp=%b want seg=%b an=%b dp=%b",
                  name, e_seg, e_an, e_dp, s, a, d);
      end
   endtask

   task automatic at_edge(input int n);
      while (t < n) @(negedge clk);
   endtask

   initial begin
      #1 rst = 1'b0;
      #1 chk_on = 1'b1;
      repeat (3) @(negedge clk);
      check_lit("reset_hold", 7'b1111111, 4'b1111, 1'b1);
      rst = 1'b1;
      at_edge(1);
      check_lit("first_edge", 7'b1000000, 4'b1110, 1'b1);
      at_edge(4);
      check_lit("dig0_last", 7'b1000000, 4'b1110, 1'b1);
      at_edge(5);
      check_lit("dig1_after4", 7'b1000000, 4'b1101, 1'b1);
      value = 8'h35;
      at_edge(17);
      check_lit("f1_dig0_5", 7'b0010010, 4'b1110, 1'b1);
      at_edge(21);
      check_lit("f1_dig1_3", 7'b0110000, 4'b1101, 1'b1);
      at_edge(22);
      mode = 1'b1;
      at_edge(25);
      check_lit("f1_dig2_A", 7'b0001000, 4'b1011, 1'b0);
      at_edge(29);
`ifdef DISP_CHANGE_CNT_EN
      check_lit("f1_dig3_cnt1", 7'b1111001, 4'b0111, 1'b1);
`else
      check_lit("f1_dig3_blank", 7'b1111111, 4'b0111, 1'b1);
`endif
      at_edge(33);
      check_lit("f2_dig0_5", 7'b0010010, 4'b1110, 1'b1);
      at_edge(38);
      value = 8'h3C;
      at_edge(41);
      check_lit("f2_dig2_P", 7'b0001100, 4'b1011, 1'b0);
      at_edge(44);
      check_lit("f2_dig2_hold", 7'b0001100, 4'b1011, 1'b0);
      at_edge(49);
      check_lit("f3_dig0_C", 7'b1000110, 4'b1110, 1'b1);
      at_edge(61);
`ifdef DISP_CHANGE_CNT_EN
      check_lit("f3_dig3_cnt2", 7'b0100100, 4'b0111, 1'b1);
`else
      check_lit("f3_dig3_blank", 7'b1111111, 4'b0111, 1'b1);
`endif
      for (int k = 0; k < 16; k++) begin
         at_edge(64 + FRAME * k + 2);
         value = 8'h40 + 8'(k);
      end
      at_edge(321);
      check_lit("f20_dig0_F", 7'b0001110, 4'b1110, 1'b1);
      at_edge(325);
      check_lit("f20_dig1_4", 7'b0011001, 4'b1101, 1'b1);
      at_edge(333);
`ifdef DISP_CHANGE_CNT_EN
      check_lit("f20_dig3_wrap", 7'b0100100, 4'b0111, 1'b1);
`else
      check_lit("f20_dig3_blank", 7'b1111111, 4'b0111, 1'b1);
`endif
      begin
         bit found;
         found = 1'b0;
         for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (an == 4'b1011) found = 1'b1;
         end
         checks++;
         if (!found) begin
            errors++;
            $display("FAIL wait_dig2 got an=%b want an=1011", an);
         end
      end
      #2 rst = 1'b0;
      #1 check_lit("async_rst", 7'b1111111, 4'b1111, 1'b1);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      at_edge(1);
      check_lit("rst2_first", 7'b1000000, 4'b1110, 1'b1);
      at_edge(4);
      check_lit("rst2_dwell", 7'b1000000, 4'b1110, 1'b1);
      at_edge(5);
      check_lit("rst2_dig1", 7'b1000000, 4'b1101, 1'b1);
      at_edge(40);
      chk_on = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
